// File: rtl/if_id_fetch_buffer_pkg.sv
// rtl/if_id_fetch_buffer_pkg.sv - shared constants for the IF/ID fetch buffer
// Optional same-cycle bypass is enabled by defining FETCH_BUF_BYPASS_EN.
package if_id_fetch_buffer_pkg;

  localparam int FETCH_BUF_DATA_W = 32;
  localparam int FETCH_BUF_DEPTH  = 4;

  // Decode substitutes this word whenever the buffer presents nothing.
  localparam logic [31:0] NOP_INSTR = 32'b0;

  function automatic int unsigned fetch_buf_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_id_fetch_buffer_if.sv
// rtl/if_id_fetch_buffer_if.sv - fetch/decode handshake bundle for the IF/ID buffer
interface if_id_fetch_buffer_if
  import if_id_fetch_buffer_pkg::*;
#(
  parameter int DATA_W = FETCH_BUF_DATA_W,
  parameter int DEPTH  = FETCH_BUF_DEPTH
);

  logic                       flush;
  logic                       in_valid;
  logic [DATA_W-1:0]          in_pc;
  logic [DATA_W-1:0]          in_instr;
  logic                       in_ready;
  logic                       out_valid;
  logic [DATA_W-1:0]          out_pc;
  logic [DATA_W-1:0]          out_instr;
  logic                       out_ready;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );

endinterface

// File: rtl/if_id_fetch_buffer_mem.sv
// rtl/if_id_fetch_buffer_mem.sv - entry storage: one write port, one asynchronous read port
module fetch_buf_mem #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: stale contents are never visible because the top masks empty reads.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_fetch_buffer.sv
// rtl/if_id_fetch_buffer.sv - in-order {PC, instruction} queue between fetch and decode
// Define FETCH_BUF_BYPASS_EN to let an empty buffer forward the input in the same cycle.
module if_id_fetch_buffer
  import if_id_fetch_buffer_pkg::*;
#(
  parameter int DEPTH  = FETCH_BUF_DEPTH,
  parameter int DATA_W = FETCH_BUF_DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  if_id_fetch_buffer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  stored_valid;
  logic                  bypass;
  logic                  push;
  logic                  pop;
  logic                  mem_we;
  logic [2*DATA_W-1:0]   head;

  always_comb begin
    stored_valid = (count_q != '0);
    bus.in_ready = (count_q != CW'(DEPTH));
`ifdef FETCH_BUF_BYPASS_EN
    bypass       = !stored_valid && bus.in_valid && !bus.flush;
`else
    bypass       = 1'b0;
`endif
    pop          = stored_valid && bus.out_ready;
    // A bypassed pair that decode takes immediately is never stored.
    push         = bus.in_valid && bus.in_ready && !(bypass && bus.out_ready);
    mem_we       = push && !reset && !bus.flush;
  end

  always_comb begin
    bus.out_valid = stored_valid || bypass;
    bus.out_pc    = '0;
    bus.out_instr = DATA_W'(NOP_INSTR);
    if (stored_valid) begin
      bus.out_pc    = head[2*DATA_W-1:DATA_W];
      bus.out_instr = head[DATA_W-1:0];
    end else if (bypass) begin
      bus.out_pc    = bus.in_pc;
      bus.out_instr = bus.in_instr;
    end
  end

  assign bus.count = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      rd_ptr  <= wr_ptr;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  fetch_buf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (2*DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata ({bus.in_pc, bus.in_instr}),
    .raddr (rd_ptr),
    .rdata (head)
  );

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// tb/tb_if_id_fetch_buffer.sv - self-checking bench for the IF/ID fetch buffer
module tb_if_id_fetch_buffer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  if_id_fetch_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  if_id_fetch_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct {
    logic        r;
    logic        f;
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    int          cnt;
    logic        ov;
    logic [31:0] opc;
    logic        ir;
  } vec_t;

  entry_t q[$];
  vec_t   tbl[25];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hE3A0_1000;
  endfunction

  function automatic vec_t mk(input logic r, f, iv, input logic [31:0] pc, input logic ordy,
                              input int cnt, input logic ov, input logic [31:0] opc, input logic ir);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.pc = pc; v.ordy = ordy;
    v.cnt = cnt; v.ov = ov; v.opc = opc; v.ir = ir;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic apply(input logic r, f, iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy);
    @(negedge clk);
    reset        = r;
    bus.flush    = f;
    bus.in_valid = iv;
    bus.in_pc    = pc;
    bus.in_instr = ins;
    bus.out_ready = ordy;
    #1;
  endtask

  // Reference model: compare this cycle's outputs, then apply the edge to the queue.
  task automatic step(input logic r, f, iv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy);
    int          n;
    logic        byp;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_in;
    logic        do_pop;
    logic        do_push;
    entry_t      e;
    apply(r, f, iv, pc, ins, ordy);
    n = q.size();
`ifdef FETCH_BUF_BYPASS_EN
    byp = (n == 0) && iv && !f;
`else
    byp = 1'b0;
`endif
    e_ov = (n != 0) || byp;
    e_pc = (n != 0) ? q[0].pc    : (byp ? pc  : 32'h0);
    e_in = (n != 0) ? q[0].instr : (byp ? ins : 32'h0);
    check("rand_count",     64'(bus.count),     64'(n));
    check("rand_out_valid", 64'(bus.out_valid), 64'(e_ov));
    check("rand_in_ready",  64'(bus.in_ready),  64'(n != DEPTH));
    check("rand_out_pc",    64'(bus.out_pc),    64'(e_pc));
    check("rand_out_instr", 64'(bus.out_instr), 64'(e_in));
    if (r || f) begin
      q.delete();
    end else begin
      do_pop  = (n > 0) && ordy;
      do_push = iv && (n < DEPTH) && !(byp && ordy);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.pc = pc;
        e.instr = ins;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] rin;

    reset = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 1'b0;

    apply(1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    check("reset_count",     64'(bus.count),     64'd0);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_pc",    64'(bus.out_pc),    64'd0);
    check("reset_out_instr", 64'(bus.out_instr), 64'd0);
    check("reset_in_ready",  64'(bus.in_ready),  64'd1);

    //          r  f  iv pc   ordy cnt ov opc  ir
    tbl[0]  = mk(0, 0, 1, 0,   0,  0, 0, 0,   1);
    tbl[1]  = mk(0, 0, 1, 4,   0,  1, 1, 0,   1);
    tbl[2]  = mk(0, 0, 1, 8,   0,  2, 1, 0,   1);
    tbl[3]  = mk(0, 0, 1, 12,  0,  3, 1, 0,   1);
    tbl[4]  = mk(0, 0, 1, 16,  0,  4, 1, 0,   0);
    tbl[5]  = mk(0, 0, 0, 0,   1,  4, 1, 0,   0);
    tbl[6]  = mk(0, 0, 0, 0,   1,  3, 1, 4,   1);
    tbl[7]  = mk(0, 0, 0, 0,   1,  2, 1, 8,   1);
    tbl[8]  = mk(0, 0, 0, 0,   1,  1, 1, 12,  1);
    tbl[9]  = mk(0, 0, 0, 0,   1,  0, 0, 0,   1);
    tbl[10] = mk(0, 0, 1, 20,  0,  0, 0, 0,   1);
    tbl[11] = mk(0, 0, 1, 24,  0,  1, 1, 20,  1);
    tbl[12] = mk(0, 0, 1, 16,  1,  2, 1, 20,  1);
    tbl[13] = mk(0, 0, 0, 0,   0,  2, 1, 24,  1);
    tbl[14] = mk(0, 0, 1, 28,  0,  2, 1, 24,  1);
    tbl[15] = mk(0, 0, 1, 32,  0,  3, 1, 24,  1);
    tbl[16] = mk(0, 0, 1, 36,  1,  4, 1, 24,  0);
    tbl[17] = mk(0, 0, 0, 0,   0,  3, 1, 16,  1);
    tbl[18] = mk(0, 1, 1, 100, 0,  3, 1, 16,  1);
    tbl[19] = mk(0, 0, 0, 0,   0,  0, 0, 0,   1);
    tbl[20] = mk(0, 0, 1, 40,  0,  0, 0, 0,   1);
    tbl[21] = mk(0, 0, 0, 0,   0,  1, 1, 40,  1);
    tbl[22] = mk(0, 0, 1, 44,  0,  1, 1, 40,  1);
    tbl[23] = mk(1, 0, 1, 52,  0,  2, 1, 40,  1);
    tbl[24] = mk(0, 0, 0, 0,   0,  0, 0, 0,   1);

`ifndef FETCH_BUF_BYPASS_EN
    for (int i = 0; i < 25; i++) begin
      apply(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].pc, instr_of(tbl[i].pc), tbl[i].ordy);
      check($sformatf("vec%0d_count", i),     64'(bus.count),     64'(tbl[i].cnt));
      check($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].ov));
      check($sformatf("vec%0d_in_ready", i),  64'(bus.in_ready),  64'(tbl[i].ir));
      check($sformatf("vec%0d_out_pc", i),    64'(bus.out_pc),    64'(tbl[i].opc));
      check($sformatf("vec%0d_out_instr", i), 64'(bus.out_instr),
            64'(tbl[i].ov ? instr_of(tbl[i].opc) : 32'h0));
    end
`endif

    // Steady-state stream across several pointer wraps.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, instr_of(0), 0);
    for (int i = 1; i < 10; i++) begin
      step(0, 0, 1, 32'(i * 4), instr_of(32'(i * 4)), 1);
      check($sformatf("wrap%0d_head", i), 64'(q[0].pc), 64'(i * 4));
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

`ifdef FETCH_BUF_BYPASS_EN
    step(1, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 32'h200, instr_of(32'h200), 1);
    check("bypass_out_pc",    64'(bus.out_pc),    64'h200);
    check("bypass_out_valid", 64'(bus.out_valid), 64'd1);
    step(0, 0, 1, 32'h200, instr_of(32'h200), 1);
    step(0, 0, 0, 0, 0, 0);
    check("bypass_count", 64'(bus.count), 64'd0);
`endif

    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      rpc = $urandom & 32'hFFFF_FFFC;
      rin = $urandom;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7,
           rpc, rin, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_buffer.md
Name: if_id_fetch_buffer

Overview:
- Consumer-side queue between the fetch stage and the decode stage of the ARM pipeline.
- Accepts {PC, Instruction} pairs from fetch with a valid/ready handshake and presents them in order to decode.
- Deasserts in_ready when full; fetch uses ~in_ready as its freeze.
- Flushes all held entries when a branch is taken.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2, minimum 2.
- DATA_W, 32, width of PC and of Instruction.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  Branch_Taken from EXE; discards all contents.
- in_valid  input  1  fetch presents a valid pair.
- in_pc  input  DATA_W  PC of the fetched instruction.
- in_instr  input  DATA_W  fetched instruction word.
- in_ready  output  1  buffer can accept; fetch freeze = ~in_ready.
- out_valid  output  1  head entry valid.
- out_pc  output  DATA_W  head PC.
- out_instr  output  DATA_W  head instruction.
- out_ready  input  1  decode accepts the head (~hazard stall).
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage and state:
  - Circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, plus count.
  - Pointers wrap naturally at DEPTH.
- Reset, sampled at a clk edge: count=0 and both pointers=0. Resulting outputs: out_valid=0, out_pc=0, out_instr=0, in_ready=1. Reset in mid-operation drops all entries.
- Push: occurs when in_valid & in_ready. The entry is written at wr_ptr, then wr_ptr+1.
- Pop: occurs when out_valid & out_ready. rd_ptr advances by 1.
- Signal definitions:
  - in_ready = (count != DEPTH). It has no combinational dependence on out_ready.
  - out_valid = (count != 0).
  - out_pc and out_instr show the head entry while out_valid=1, and are forced to 0 when empty.
- Latency: an entry pushed at edge N appears at the outputs after edge N (first-word-fall-through, 1 cycle).
- Simultaneous events:
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - Full with out_ready=1: the pop happens, but no push occurs that cycle because in_ready=0. in_ready rises on the next cycle.
  - Empty with out_ready=1: no pop, no underflow.
- Flush (synchronous):
  - Sets count=0 and rd_ptr=wr_ptr.
  - Has priority over push and pop in the same cycle; the incoming pair is discarded.
  - out_valid=0 on the cycle after the edge.
- Reset has priority over flush.
- Ordering: strict FIFO. Entries are never reordered or duplicated.

Optional Feature:
- Macro: FETCH_BUF_BYPASS_EN.
- Defined: when count==0, in_valid=1 and flush=0, the input drives out_valid, out_pc and out_instr combinationally in the same cycle.
  - If out_ready=1, the pair is consumed and not stored.
  - If out_ready=0, the pair is stored as normal.
- Undefined: minimum latency is 1 cycle, as described above.

Decomposition:
- Shared package holds:
  - DATA_W default (32).
  - NOP instruction constant, 32'b0, which decode substitutes when out_valid=0.
  - Default DEPTH constant.
- One natural sub-module: fetch_buf_mem. It is the DEPTH x (2*DATA_W) register array with one write port and one asynchronous read port.
- Pointer, count and handshake logic stay in the top.

Test Plan:
- Reset: assert reset for 2 cycles -> count=0, out_valid=0, out_pc=0, in_ready=1.
- Fill/drain: push PCs 0,4,8,12 with out_ready=0 -> count=4 and in_ready=0. Raise out_ready -> out_pc sequence 0,4,8,12 on consecutive cycles, then out_valid=0.
- Simultaneous push/pop: hold count=2 while pushing PC=16 and popping -> count stays 2 and the head advances by one entry.
- Full plus pop: at count=4 with in_valid=1 and out_ready=1 -> no push that cycle, count=3; next cycle in_ready=1.
- Flush: count=3 with flush=1 and in_valid=1 (PC=100) -> next cycle count=0 and out_valid=0; PC=100 never appears.
- Wrap-around: push and pop 10 entries (PCs 0..36) at steady state -> order preserved across pointer wrap. With FETCH_BUF_BYPASS_EN defined and the buffer empty, in_valid=1 and out_ready=1 -> out_pc equals in_pc in the same cycle and count stays 0.
